// File: rtl/prog_sequencer.sv
// prog_sequencer: program-counter sequencer with relative/absolute jumps and
// an optional call/return stack.
//
// Optional feature: define PROG_SEQ_STACK_EN to compile in the SD-entry
// return stack (call/ret). Without it, call/ret are ignored and fault is 0.
//
// Ports:
//   clk        in  clock, all state changes on rising edge
//   reset      in  asynchronous active-low reset
//   req        in  level run request
//   start_addr in  first PC of a run, sampled on IDLE->RUN
//   stall      in  hold PC and stack this cycle
//   relj       in  relative jump (prog_ctr + rel_off, modulo 2^D)
//   rel_off    in  signed relative offset
//   absj       in  absolute jump to target
//   target     in  absolute / call destination
//   call       in  push prog_ctr+1, jump to target
//   ret        in  pop return address into PC
//   prog_ctr   out current program counter
//   busy       out high in RUN
//   done       out high in DONE
//   fault      out high in FAULT
//
// Handshake: req is a level request. The host holds req high to run; the
// run ends in DONE (PC reached END_ADDR) or FAULT, and the sequencer stays
// there until the host drops req, which returns it to IDLE. Dropping req
// during RUN abandons the run without a done indication.
module prog_sequencer #(
  parameter int D        = 12,
  parameter int END_ADDR = 128,
  parameter int SD       = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic [D-1:0] start_addr,
  input  logic         stall,
  input  logic         relj,
  input  logic [D-1:0] rel_off,
  input  logic         absj,
  input  logic [D-1:0] target,
  input  logic         call,
  input  logic         ret,
  output logic [D-1:0] prog_ctr,
  output logic         busy,
  output logic         done,
  output logic         fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [D-1:0] END_PC = D'(END_ADDR);

  state_t       state, state_next;
  logic [D-1:0] pc_next;

`ifdef PROG_SEQ_STACK_EN
  localparam int SP_W  = $clog2(SD + 1);
  localparam int IDX_W = (SD > 1) ? $clog2(SD) : 1;

  logic [D-1:0]    stack_mem [SD];
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_m1;
  logic            push, pop;

  assign sp_m1 = sp - SP_W'(1);
`else
  // call/ret have no effect in this build.
  logic unused_stack_ports;
  assign unused_stack_ports = &{1'b0, call, ret};
`endif

  // Next state / next PC. End-of-program check comes first so it overrides
  // every control, stall included.
  always_comb begin
    state_next = state;
    pc_next    = prog_ctr;
`ifdef PROG_SEQ_STACK_EN
    push       = 1'b0;
    pop        = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (req) begin
          state_next = RUN;
          pc_next    = start_addr;
        end
      end
      RUN: begin
        if (prog_ctr == END_PC) begin
          state_next = DONE;
        end else if (!req) begin
          state_next = IDLE;
        end else if (stall) begin
          pc_next = prog_ctr;
`ifdef PROG_SEQ_STACK_EN
        end else if (ret) begin
          // ret beats call when both are raised; underflow faults with
          // PC and stack untouched.
          if (sp == '0) begin
            state_next = FAULT;
          end else begin
            pop     = 1'b1;
            pc_next = stack_mem[sp_m1[IDX_W-1:0]];
          end
        end else if (call) begin
          if (sp == SP_W'(SD)) begin
            state_next = FAULT;
          end else begin
            push    = 1'b1;
            pc_next = target;
          end
`endif
        end else if (absj) begin
          pc_next = target;
        end else if (relj) begin
          pc_next = prog_ctr + rel_off;  // wraps modulo 2^D
        end else begin
          pc_next = prog_ctr + D'(1);
        end
      end
      DONE, FAULT: begin
        if (!req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      prog_ctr <= '0;
    end else begin
      state    <= state_next;
      prog_ctr <= pc_next;
    end
  end

`ifdef PROG_SEQ_STACK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp <= '0;
    end else if (state == IDLE && req) begin
      sp <= '0;
    end else if (push) begin
      sp <= sp + SP_W'(1);
    end else if (pop) begin
      sp <= sp_m1;
    end
  end

  // Stack storage needs no reset: entries are only read below the pointer.
  always_ff @(posedge clk) begin
    if (push) stack_mem[sp[IDX_W-1:0]] <= prog_ctr + D'(1);
  end

  assign fault = (state == FAULT);
`else
  assign fault = 1'b0;
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed steps for the key scenarios followed by a
// randomized phase, all checked against a queue-based reference model.
// Works with or without PROG_SEQ_STACK_EN defined.
module tb_prog_sequencer;

  localparam int D        = 12;
  localparam int END_ADDR = 128;
  localparam int SD       = 4;
  localparam int MOD      = 1 << D;

`ifdef PROG_SEQ_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         req, stall, relj, absj, call, ret;
  logic [D-1:0] start_addr, rel_off, target;
  logic [D-1:0] prog_ctr;
  logic         busy, done, fault;

  always #5 clk = ~clk;

  prog_sequencer #(.D(D), .END_ADDR(END_ADDR), .SD(SD)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .req        (req),
    .start_addr (start_addr),
    .stall      (stall),
    .relj       (relj),
    .rel_off    (rel_off),
    .absj       (absj),
    .target     (target),
    .call       (call),
    .ret        (ret),
    .prog_ctr   (prog_ctr),
    .busy       (busy),
    .done       (done),
    .fault      (fault)
  );

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_RUN, M_DONE, M_FAULT} mstate_t;
  mstate_t m_state;
  int      m_pc;
  int      m_stack[$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic model_reset();
    m_state = M_IDLE;
    m_pc    = 0;
    m_stack.delete();
  endtask

  // Applies one rising edge to the model using the inputs held at that edge.
  task automatic model_edge();
    case (m_state)
      M_IDLE: if (req) begin
        m_state = M_RUN;
        m_pc    = int'(start_addr);
        m_stack.delete();
      end
      M_RUN: begin
        if (m_pc == END_ADDR)   m_state = M_DONE;
        else if (!req)          m_state = M_IDLE;
        else if (stall)         m_pc = m_pc;
        else if (STACK_EN && ret) begin
          if (m_stack.size() == 0) m_state = M_FAULT;
          else                     m_pc = m_stack.pop_back();
        end else if (STACK_EN && call) begin
          if (m_stack.size() == SD) m_state = M_FAULT;
          else begin
            m_stack.push_back((m_pc + 1) % MOD);
            m_pc = int'(target);
          end
        end
        else if (absj) m_pc = int'(target);
        else if (relj) m_pc = (m_pc + int'(signed'(rel_off)) + MOD) % MOD;
        else           m_pc = (m_pc + 1) % MOD;
      end
      default: if (!req) m_state = M_IDLE;
    endcase
  endtask

  // ---------------- scoreboard ----------------
  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".pc"},    32'(prog_ctr), 32'(m_pc));
    cmp({tag, ".busy"},  32'(busy),     32'(m_state == M_RUN));
    cmp({tag, ".done"},  32'(done),     32'(m_state == M_DONE));
    cmp({tag, ".fault"}, 32'(fault),    32'(m_state == M_FAULT));
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_ctl();
    stall = 0; relj = 0; absj = 0; call = 0; ret = 0;
    rel_off = '0; target = '0;
  endtask

  // One clock: edge, model update, sample #1 later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic go_idle();
    clear_ctl();
    req = 0;
    step("to_idle");
  endtask

  task automatic start_run(input int addr);
    start_addr = D'(addr);
    req = 1;
    step("start");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0; req = 0; start_addr = '0;
    clear_ctl();
    model_reset();
    #3;
    check_all("reset");
    repeat (2) step("in_reset");
    @(negedge clk);
    rst_n = 1;
    step("post_reset_idle");

    // Straight run 120..128, then DONE held until req drops.
    start_run(120);
    for (int i = 0; i < 12; i++) step("run_to_end");
    step("done_hold");
    go_idle();

    // Relative jump backwards, then wrap from 4095 to 0.
    start_run(100);
    relj = 1; rel_off = 12'hFF6;
    step("relj_neg");
    clear_ctl(); absj = 1; target = 12'd4095;
    step("abs_4095");
    clear_ctl();
    step("wrap_0");
    step("after_wrap");
    go_idle();

    // Stall beats jumps; releasing stall lets absj win over relj.
    start_run(50);
    stall = 1; absj = 1; relj = 1; target = 12'd7; rel_off = 12'd3;
    step("stall_hold");
    stall = 0;
    step("abs_over_rel");
    go_idle();

    // Four calls fill the stack, fifth overflows.
    start_run(10);
    for (int i = 2; i <= 5; i++) begin
      clear_ctl(); call = 1; target = D'(i * 10);
      step("call_fill");
    end
    target = 12'd900;
    step("call_overflow");
    step("overflow_hold");
    go_idle();

    // Call then return.
    start_run(10);
    clear_ctl(); call = 1; target = 12'd60;
    step("call_one");
    clear_ctl(); ret = 1;
    step("ret_one");
    go_idle();

    // Return from empty stack.
    start_run(30);
    clear_ctl(); ret = 1;
    step("ret_empty");
    go_idle();

    // call and ret together: ret wins.
    start_run(200);
    clear_ctl(); call = 1; target = 12'd300;
    step("call_pre");
    ret = 1; target = 12'd400;
    step("call_ret_same");
    go_idle();

    // Randomized phase.
    for (int n = 0; n < 400; n++) begin
      req        = ($urandom_range(0, 19) != 0);
      stall      = ($urandom_range(0, 7) == 0);
      ret        = ($urandom_range(0, 9) == 0);
      call       = ($urandom_range(0, 7) == 0);
      absj       = ($urandom_range(0, 7) == 0);
      relj       = ($urandom_range(0, 3) == 0);
      rel_off    = D'($urandom_range(0, MOD - 1));
      target     = ($urandom_range(0, 3) == 0) ? D'($urandom_range(120, 127))
                                               : D'($urandom_range(0, MOD - 1));
      start_addr = ($urandom_range(0, 1) == 0) ? D'($urandom_range(118, 128))
                                               : D'($urandom_range(0, MOD - 1));
      step("random");
    end
    go_idle();

    // Asynchronous reset between edges mid-run at PC 77.
    start_run(70);
    clear_ctl();
    for (int i = 0; i < 7; i++) step("run_to_77");
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    req = 0;
    rst_n = 1;
    step("idle_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
